modadd_scalar_ctrl: RTL and testbench

//  Initiator side of the modular add/sub start/done handshake. Computes result = (k * a) mod m
//  by MSB-first double-and-add, issuing one modular add per step to an external modular

---
 rtl/modadd_scalar_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_modadd_scalar_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/modadd_scalar_ctrl.sv
// Scalar-multiply controller: result = (k*a) mod m by MSB-first double-and-add on an external modular adder.
// Optional MODADD_SCALAR_NEG_EN adds in_neg and a final subtract-from-zero step.
module modadd_scalar_ctrl #(
  parameter int WIDTH = 381,
  parameter int KBITS = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [KBITS-1:0] in_k,
  input  logic [WIDTH-1:0] in_m,
`ifdef MODADD_SCALAR_NEG_EN
  input  logic             in_neg,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] add_m,
  output logic             add_subtract,
  output logic             add_start,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_done,
  output logic [2:0]       dbg_state
);

  localparam int IDX_W = (KBITS > 1) ? $clog2(KBITS) : 1;
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(KBITS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DBL_ISSUE = 3'd1;
  localparam logic [2:0] DBL_WAIT  = 3'd2;
  localparam logic [2:0] ADD_ISSUE = 3'd3;
  localparam logic [2:0] ADD_WAIT  = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
`ifdef MODADD_SCALAR_NEG_EN
  localparam logic [2:0] NEG_ISSUE = 3'd6;
  localparam logic [2:0] NEG_WAIT  = 3'd7;
`endif

  logic [2:0]       state, state_d;
  logic [WIDTH-1:0] a_r;
  logic [KBITS-1:0] k_r;
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] idx;
`ifdef MODADD_SCALAR_NEG_EN
  logic             neg_r;
`endif

  logic [WIDTH-1:0] op_a_d, op_b_d;
  logic             sub_d;
  logic             acc_load, idx_dec, res_load, step_end;

  // Handshake: add_start is a one-cycle pulse in an ISSUE state; operands are
  // registered on entry to ISSUE and held unchanged until add_done is seen in WAIT.
  assign add_start = (state == DBL_ISSUE) || (state == ADD_ISSUE)
`ifdef MODADD_SCALAR_NEG_EN
                     || (state == NEG_ISSUE)
`endif
                     ;
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_d  = state;
    op_a_d   = add_a;
    op_b_d   = add_b;
    sub_d    = add_subtract;
    acc_load = 1'b0;
    idx_dec  = 1'b0;
    res_load = 1'b0;
    step_end = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = DBL_ISSUE;
          op_a_d  = '0;
          op_b_d  = '0;
          sub_d   = 1'b0;
        end
      end
      DBL_ISSUE: state_d = DBL_WAIT;
      DBL_WAIT: begin
        if (add_done) begin
          acc_load = 1'b1;
          if (k_r[idx]) begin
            state_d = ADD_ISSUE;
            op_a_d  = add_result;
            op_b_d  = a_r;
            sub_d   = 1'b0;
          end else begin
            step_end = 1'b1;
          end
        end
      end
      ADD_ISSUE: state_d = ADD_WAIT;
      ADD_WAIT: begin
        if (add_done) begin
          acc_load = 1'b1;
          step_end = 1'b1;
        end
      end
`ifdef MODADD_SCALAR_NEG_EN
      NEG_ISSUE: state_d = NEG_WAIT;
      NEG_WAIT: begin
        if (add_done) begin
          acc_load = 1'b1;
          res_load = 1'b1;
          state_d  = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // End of a bit step: either finish or start the next doubling with the fresh acc.
    if (step_end) begin
      if (idx == '0) begin
`ifdef MODADD_SCALAR_NEG_EN
        if (neg_r) begin
          state_d = NEG_ISSUE;
          op_a_d  = '0;
          op_b_d  = add_result;
          sub_d   = 1'b1;
        end else begin
          res_load = 1'b1;
          state_d  = DONE;
        end
`else
        res_load = 1'b1;
        state_d  = DONE;
`endif
      end else begin
        idx_dec = 1'b1;
        state_d = DBL_ISSUE;
        op_a_d  = add_result;
        op_b_d  = add_result;
        sub_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      a_r          <= '0;
      k_r          <= '0;
      acc          <= '0;
      idx          <= IDX_INIT;
      result       <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_m        <= '0;
      add_subtract <= 1'b0;
`ifdef MODADD_SCALAR_NEG_EN
      neg_r        <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      add_a        <= op_a_d;
      add_b        <= op_b_d;
      add_subtract <= sub_d;
      if (state == IDLE && start) begin
        a_r   <= in_a;
        k_r   <= in_k;
        add_m <= in_m;
        acc   <= '0;
        idx   <= IDX_INIT;
`ifdef MODADD_SCALAR_NEG_EN
        neg_r <= in_neg;
`endif
      end
      if (acc_load) acc <= add_result;
      if (idx_dec)  idx <= idx - 1'b1;
      if (res_load) result <= add_result;
    end
  end

endmodule

// File: tb/tb_modadd_scalar_ctrl.sv
// Self-checking bench for modadd_scalar_ctrl: registered modular adder stub with latency lat,
// directed timing cases, reset abort, and random (a<m, k) against a plain-arithmetic model.
module tb_modadd_scalar_ctrl;
  localparam int W  = 64;
  localparam int KB = 16;
`ifdef MODADD_SCALAR_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_a = '0, in_m = '0;
  logic [KB-1:0] in_k = '0;
  logic          in_neg = 1'b0;
  logic          busy, done, add_subtract, add_start, add_done;
  logic [W-1:0]  result, add_a, add_b, add_m, add_result;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int lat      = 3;
  int rst_epoch = 0;
  logic [W-1:0] exp_q[$];

  modadd_scalar_ctrl #(.WIDTH(W), .KBITS(KB)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_a(in_a), .in_k(in_k), .in_m(in_m),
`ifdef MODADD_SCALAR_NEG_EN
    .in_neg(in_neg),
`endif
    .busy(busy), .done(done), .result(result),
    .add_a(add_a), .add_b(add_b), .add_m(add_m),
    .add_subtract(add_subtract), .add_start(add_start),
    .add_result(add_result), .add_done(add_done),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [KB-1:0] k,
                                             input logic [W-1:0] m, input logic neg);
    logic [W+KB-1:0] p;
    logic [W-1:0]    r;
    p = {{KB{1'b0}}, a} * {{W{1'b0}}, k};
    p = p % {{KB{1'b0}}, m};
    r = p[W-1:0];
    if (neg && r != '0) r = m - r;
    return r;
  endfunction

  // adder stub: registered mod add/sub, add_done lat cycles after add_start
  logic [W-1:0] st_a, st_b, st_m;
  logic         st_s;
  logic [W:0]   st_sum;
  int           st_ep;
  initial begin
    add_done   = 1'b0;
    add_result = '0;
    forever begin
      @(negedge clk);
      if (resetn && add_start) begin
        st_ep = rst_epoch;
        st_a = add_a; st_b = add_b; st_m = add_m; st_s = add_subtract;
        if (!st_s) begin
          st_sum = {1'b0, st_a} + {1'b0, st_b};
          if (st_sum >= {1'b0, st_m}) st_sum = st_sum - {1'b0, st_m};
        end else if (st_a >= st_b) begin
          st_sum = {1'b0, st_a} - {1'b0, st_b};
        end else begin
          st_sum = {1'b0, st_a} + {1'b0, st_m} - {1'b0, st_b};
        end
        repeat (lat) @(posedge clk);
        #1 add_done = 1'b1; add_result = st_sum[W-1:0];
        @(negedge clk);
        if (resetn && st_ep == rst_epoch) begin
          check("op_a_stable", add_a, st_a);
          check("op_b_stable", add_b, st_b);
          check("op_m_stable", add_m, st_m);
          check("op_sub_stable", W'(add_subtract), W'(st_s));
        end
        @(posedge clk);
        #1 add_done = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [KB-1:0] k, input logic [W-1:0] m,
                        input logic neg, input bit dup);
    int t0, first_as, n_as, nops, done_at;
    bit seen;
    logic [W-1:0] exp;
    nops = KB + $countones(k) + (neg ? 1 : 0);
    exp_q.push_back(ref_model(a, k, m, neg));
    @(posedge clk); #1;
    in_a = a; in_k = k; in_m = m; in_neg = neg; start = 1'b1;
    t0 = cyc;
    seen = 0; first_as = -1; n_as = 0; done_at = -1;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(posedge clk); #1;
      if (dup && cyc - t0 == 10) begin
        start = 1'b1;
        in_a = {$urandom, $urandom}; in_k = KB'($urandom); in_m = {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (add_start) begin
        if (first_as < 0) first_as = cyc - t0;
        n_as++;
      end
      if (cyc - t0 == 1) check("busy_after_start", W'(busy), 1);
      if (done) begin
        seen = 1;
        done_at = cyc - t0;
      end
    end
    check("done_seen", W'(seen), 1);
    exp = exp_q.pop_front();
    if (seen) begin
      check("result", result, exp);
      check("done_cycle", W'(done_at), W'(1 + nops * (lat + 1)));
      check("first_add_start", W'(first_as), 1);
      check("add_start_count", W'(n_as), W'(nops));
      check("busy_at_done", W'(busy), 0);
      @(negedge clk);
      check("done_one_cycle", W'(done), 0);
      check("result_held", result, exp);
    end
  endtask

  task automatic reset_abort_test();
    int t0;
    bit stale;
    @(posedge clk); #1;
    in_a = 5; in_k = 3; in_m = 7; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc - t0 < 30) begin
      @(posedge clk); #1;
    end
    rst_epoch++;
    resetn = 1'b0;
    #1;
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_result", result, 0);
    check("rst_add_start", W'(add_start), 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_m", add_m, 0);
    check("rst_add_sub", W'(add_subtract), 0);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b1;
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) stale = 1;
    end
    check("no_stale_activity", W'(stale), 0);
  endtask

  initial begin
    logic [W-1:0]  ra, rm;
    logic [KB-1:0] rk;
    logic          rn;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", W'(busy), 0);
    check("reset_done", W'(done), 0);
    check("reset_result", result, 0);
    check("reset_add_start", W'(add_start), 0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    lat = 3;
    run_op(5, 3, 7, 1'b0, 1'b0);
    run_op(9, 0, 11, 1'b0, 1'b0);
    run_op(12, 16'hFFFF, 13, 1'b0, 1'b0);
    run_op(5, 3, 7, 1'b0, 1'b1);
`ifdef MODADD_SCALAR_NEG_EN
    run_op(5, 3, 7, 1'b1, 1'b0);
`endif
    reset_abort_test();
    run_op(5, 3, 7, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      lat = $urandom_range(1, 4);
      rm = {$urandom, $urandom};
      if (n % 10 == 0) rm = {W{1'b1}};
      if (rm < 2) rm = 2;
      ra = {$urandom, $urandom} % rm;
      if (n % 10 == 1) ra = rm - 1;
      case ($urandom_range(0, 5))
        0:       rk = '0;
        1:       rk = '1;
        default: rk = KB'($urandom);
      endcase
      rn = NEG_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op(ra, rk, rm, rn, n % 25 == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
